// File: rtl/acc_control_unit.sv
// Multi-cycle control unit for a 4-bit accumulator core: fetch, decode, optional ALU wait, execute.
// Define ACC_CTRL_ILLEGAL_TRAP_EN to halt on opcodes 0x6-0xE with IllegalOp; otherwise they run as NOP.
module acc_control_unit #(
    parameter int unsigned PC_W = 8
) (
    input  logic            CLK,
    input  logic            CLB,
    input  logic [7:0]      Instr,
    input  logic            InstrValid,
    output logic            InstrReq,
    output logic [PC_W-1:0] PC,
    output logic [3:0]      A_Imm,
    output logic            LoadAcc,
    output logic            SelAcc1,
    output logic            SelAcc0,
    output logic [1:0]      RegSel,
    output logic            LoadReg,
    output logic [2:0]      AluOp,
    output logic            Halted,
    output logic            IllegalOp
);

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpAddr = 4'h2;
    localparam logic [3:0] OpAlu  = 4'h3;
    localparam logic [3:0] OpStr  = 4'h4;
    localparam logic [3:0] OpJmp  = 4'h5;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StAluWait,
        StExec,
        StHalt
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [7:0]      ir_q;
    logic [3:0]      a_imm_q;
    logic            load_acc_q;
    logic            sel_acc1_q;
    logic            sel_acc0_q;
    logic [1:0]      reg_sel_q;
    logic            load_reg_q;
    logic [2:0]      alu_op_q;

    // Control outputs are registered on the edge entering the state that owns them,
    // so they default to zero every cycle and only the decode/ALU-wait edges raise them.
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            ir_q       <= '0;
            a_imm_q    <= '0;
            load_acc_q <= 1'b0;
            sel_acc1_q <= 1'b0;
            sel_acc0_q <= 1'b0;
            reg_sel_q  <= '0;
            load_reg_q <= 1'b0;
            alu_op_q   <= '0;
        end else begin
            a_imm_q    <= '0;
            load_acc_q <= 1'b0;
            sel_acc1_q <= 1'b0;
            sel_acc0_q <= 1'b0;
            reg_sel_q  <= '0;
            load_reg_q <= 1'b0;
            alu_op_q   <= '0;
            case (state_q)
                StFetch: begin
                    if (InstrValid) begin
                        ir_q    <= Instr;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    case (ir_q[7:4])
                        OpAlu: begin
                            alu_op_q <= ir_q[2:0];
                            state_q  <= StAluWait;
                        end
                        OpHalt: state_q <= StHalt;
                        OpAddi: begin
                            a_imm_q    <= ir_q[3:0];
                            load_acc_q <= 1'b1;
                            state_q    <= StExec;
                        end
                        OpAddr: begin
                            reg_sel_q  <= ir_q[1:0];
                            sel_acc0_q <= 1'b1;
                            load_acc_q <= 1'b1;
                            state_q    <= StExec;
                        end
                        OpStr: begin
                            reg_sel_q  <= ir_q[1:0];
                            load_reg_q <= 1'b1;
                            state_q    <= StExec;
                        end
                        OpNop, OpJmp: state_q <= StExec;
                        default: begin
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
                            state_q <= StHalt;
`else
                            state_q <= StExec;
`endif
                        end
                    endcase
                end
                StAluWait: begin
                    alu_op_q   <= ir_q[2:0];
                    sel_acc1_q <= 1'b1;
                    load_acc_q <= 1'b1;
                    state_q    <= StExec;
                end
                StExec: begin
                    if (ir_q[7:4] == OpJmp) begin
                        pc_q <= PC_W'(ir_q[3:0]);
                    end else begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                    state_q <= StFetch;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Gated by CLB so the request is low while reset is held yet high right after release.
    assign InstrReq = (state_q == StFetch) && CLB;
    assign PC       = pc_q;
    assign A_Imm    = a_imm_q;
    assign LoadAcc  = load_acc_q;
    assign SelAcc1  = sel_acc1_q;
    assign SelAcc0  = sel_acc0_q;
    assign RegSel   = reg_sel_q;
    assign LoadReg  = load_reg_q;
    assign AluOp    = alu_op_q;
    assign Halted   = (state_q == StHalt);

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    // Only 0xF and the trapped opcodes reach HALT, so anything but 0xF there is illegal.
    assign IllegalOp = (state_q == StHalt) && (ir_q[7:4] != OpHalt);
`else
    assign IllegalOp = 1'b0;
`endif

endmodule
